// File: rtl/if_fetch_unit.sv
// IF stage and IF/ID pipeline register: owns the PC, addresses the synchronous instruction ROM,
// and holds, advances or flushes the instruction handed to ID while counting fetch/stall cycles.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 14,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              WPC,
  input  logic              ID_stall,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  output logic [31:0]       IF_pc,
  output logic [31:0]       ID_pc,
  output logic [31:0]       ID_pc_plus4,
  output logic [31:0]       ID_inst,
  output logic              ID_valid,
  output logic              misalign,
  output logic              seq_err,
  output logic [31:0]       fetch_cnt,
  output logic [31:0]       stall_cnt
);

  typedef enum logic [1:0] {
    ID_RESET,
    ID_FLUSH,
    ID_HOLD,
    ID_LOAD
  } id_action_t;

  logic [31:0] next_pc;
  id_action_t  id_action;

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    next_pc   = IF_pc;
    id_action = ID_LOAD;
    if (reset) begin
      next_pc   = RESET_PC;
      id_action = ID_RESET;
    end else if (redirect) begin
      next_pc   = {redirect_pc[31:2], 2'b00};
      id_action = ID_FLUSH;
    end else begin
      if (WPC) next_pc = IF_pc + 32'd4;
      if (ID_stall) id_action = ID_HOLD;
    end
  end

  // The ROM registers this address, so imem_data always returns the word at IF_pc.
  assign imem_addr = next_pc[ADDR_W+1:2];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    IF_pc <= next_pc;
    unique case (id_action)
      ID_RESET: begin
        ID_pc       <= 32'h0;
        ID_pc_plus4 <= 32'h0;
        ID_inst     <= NOP_INST;
        ID_valid    <= 1'b0;
        misalign    <= 1'b0;
        seq_err     <= 1'b0;
        fetch_cnt   <= 32'h0;
        stall_cnt   <= 32'h0;
      end
      ID_FLUSH: begin
        ID_pc       <= 32'h0;
        ID_pc_plus4 <= 32'h0;
        ID_inst     <= NOP_INST;
        ID_valid    <= 1'b0;
      end
      ID_HOLD: begin
        stall_cnt <= stall_cnt + 32'd1;
        // A PC write during a stall drops the IF word; flag the hazard unit permanently.
        if (WPC) seq_err <= 1'b1;
      end
      ID_LOAD: begin
        ID_pc       <= IF_pc;
        ID_pc_plus4 <= IF_pc + 32'd4;
        ID_inst     <= imem_data;
        ID_valid    <= 1'b1;
        fetch_cnt   <= fetch_cnt + 32'd1;
      end
      default: ;
    endcase
    if (!reset) misalign <= redirect & (|redirect_pc[1:0]);
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios plus randomized legal hazard-unit
// traffic, compared against a cycle-level reference model of the fetch rules.
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          ADDR_W   = 14;
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  logic              clock;
  logic              reset;
  logic              WPC;
  logic              ID_stall;
  logic              redirect;
  logic [31:0]       redirect_pc;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_data;
  logic [31:0]       IF_pc;
  logic [31:0]       ID_pc;
  logic [31:0]       ID_pc_plus4;
  logic [31:0]       ID_inst;
  logic              ID_valid;
  logic              misalign;
  logic              seq_err;
  logic [31:0]       fetch_cnt;
  logic [31:0]       stall_cnt;

  if_fetch_unit #(
    .RESET_PC(RESET_PC),
    .ADDR_W  (ADDR_W),
    .NOP_INST(NOP_INST)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .WPC        (WPC),
    .ID_stall   (ID_stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .IF_pc      (IF_pc),
    .ID_pc      (ID_pc),
    .ID_pc_plus4(ID_pc_plus4),
    .ID_inst    (ID_inst),
    .ID_valid   (ID_valid),
    .misalign   (misalign),
    .seq_err    (seq_err),
    .fetch_cnt  (fetch_cnt),
    .stall_cnt  (stall_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous ROM: one cycle of read latency.
  logic [31:0] rom [0:(1<<ADDR_W)-1];
  always @(posedge clock) imem_data <= rom[imem_addr];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: what the pipeline should hold after each edge.
  logic [31:0] m_pc, m_id_pc, m_id_pc4, m_id_inst, m_fetch, m_stall;
  logic        m_id_valid, m_mis, m_seq;

  // Apply the fetch rules for the inputs present at this edge.
  task automatic model_update();
    logic [31:0] inst;
    if (reset) begin
      m_pc = RESET_PC; m_id_pc = 0; m_id_pc4 = 0; m_id_inst = NOP_INST;
      m_id_valid = 0; m_mis = 0; m_seq = 0; m_fetch = 0; m_stall = 0;
    end else begin
      inst  = rom[m_pc[ADDR_W+1:2]];
      m_mis = redirect && (redirect_pc[1:0] != 2'b00);
      if (WPC && ID_stall && !redirect) m_seq = 1;
      if (redirect) begin
        m_id_pc = 0; m_id_pc4 = 0; m_id_inst = NOP_INST; m_id_valid = 0;
      end else if (ID_stall) begin
        m_stall = m_stall + 1;
      end else begin
        m_id_pc = m_pc; m_id_pc4 = m_pc + 4; m_id_inst = inst; m_id_valid = 1;
        m_fetch = m_fetch + 1;
      end
      if (redirect)  m_pc = redirect_pc & ~32'h3;
      else if (WPC)  m_pc = m_pc + 4;
    end
  endtask

  task automatic drive(input logic rst, input logic w, input logic s, input logic r,
                       input logic [31:0] rpc);
    @(negedge clock);
    reset = rst; WPC = w; ID_stall = s; redirect = r; redirect_pc = rpc;
  endtask

  task automatic edge_update();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic cycle(input logic rst, input logic w, input logic s, input logic r,
                       input logic [31:0] rpc);
    drive(rst, w, s, r, rpc);
    edge_update();
  endtask

  task automatic test_reset();
    cycle(1, 0, 0, 0, 0);
    cycle(1, 1, 1, 1, 32'h42);
    n_cmp++;
    if ({IF_pc, ID_pc, ID_pc_plus4, ID_inst, ID_valid, misalign, seq_err, fetch_cnt, stall_cnt}
        !== {RESET_PC, 32'h0, 32'h0, NOP_INST, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0}) begin
      n_bad++;
      $display("FAIL reset_state: got pc=%h idpc=%h idpc4=%h inst=%h v=%b mis=%b seq=%b fc=%h sc=%h",
               IF_pc, ID_pc, ID_pc_plus4, ID_inst, ID_valid, misalign, seq_err, fetch_cnt, stall_cnt);
    end
  endtask

  task automatic test_free_run();
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, 0, 0, 0);
      n_cmp++;
      if (ID_pc !== 32'(4*i) || ID_inst !== 32'(i+1) || ID_valid !== 1'b1
          || ID_pc_plus4 !== 32'(4*i+4)) begin
        n_bad++;
        $display("FAIL free_run_%0d: got pc=%h inst=%h v=%b pc4=%h want pc=%h inst=%h v=1 pc4=%h",
                 i, ID_pc, ID_inst, ID_valid, ID_pc_plus4, 4*i, i+1, 4*i+4);
      end
    end
    n_cmp++;
    if (fetch_cnt !== 32'd4) begin
      n_bad++; $display("FAIL free_run_fetch_cnt: got %0d want 4", fetch_cnt);
    end
    n_cmp++;
    if (IF_pc !== 32'h10 || imem_addr !== 14'd5) begin
      n_bad++; $display("FAIL free_run_pc: got IF_pc=%h imem_addr=%h want 10 / 5", IF_pc, imem_addr);
    end
  endtask

  task automatic test_stall();
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 1, 0, 0);
      n_cmp++;
      if (ID_inst !== 32'd2 || ID_pc !== 32'h4 || IF_pc !== 32'h8) begin
        n_bad++;
        $display("FAIL stall_hold_%0d: got inst=%h idpc=%h ifpc=%h want 2/4/8", i, ID_inst, ID_pc, IF_pc);
      end
    end
    n_cmp++;
    if (stall_cnt !== 32'd3) begin
      n_bad++; $display("FAIL stall_cnt: got %0d want 3", stall_cnt);
    end
    cycle(0, 1, 0, 0, 0);
    n_cmp++;
    if (ID_inst !== 32'd3 || ID_pc !== 32'h8) begin
      n_bad++; $display("FAIL stall_release1: got inst=%h pc=%h want 3/8", ID_inst, ID_pc);
    end
    cycle(0, 1, 0, 0, 0);
    n_cmp++;
    if (ID_inst !== 32'd4 || ID_pc !== 32'hC || fetch_cnt !== 32'd4) begin
      n_bad++;
      $display("FAIL stall_release2: got inst=%h pc=%h fc=%0d want 4/c/4", ID_inst, ID_pc, fetch_cnt);
    end
  endtask

  task automatic test_redirect_during_stall();
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 1, 1, 32'h40);
    n_cmp++;
    if (ID_valid !== 1'b0 || ID_inst !== NOP_INST || IF_pc !== 32'h40 || stall_cnt !== 32'd1) begin
      n_bad++;
      $display("FAIL redirect_bubble: got v=%b inst=%h ifpc=%h sc=%0d want 0/%h/40/1",
               ID_valid, ID_inst, IF_pc, stall_cnt, NOP_INST);
    end
    cycle(0, 1, 0, 0, 0);
    n_cmp++;
    if (ID_valid !== 1'b1 || ID_pc !== 32'h40 || ID_inst !== rom[16] || stall_cnt !== 32'd1) begin
      n_bad++;
      $display("FAIL redirect_target: got v=%b pc=%h inst=%h sc=%0d want 1/40/%h/1",
               ID_valid, ID_pc, ID_inst, stall_cnt, rom[16]);
    end
  endtask

  task automatic test_misalign();
    cycle(0, 1, 0, 1, 32'h42);
    n_cmp++;
    if (misalign !== 1'b1 || IF_pc !== 32'h40 || ID_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL misalign_set: got mis=%b ifpc=%h v=%b want 1/40/0", misalign, IF_pc, ID_valid);
    end
    cycle(0, 1, 0, 0, 0);
    n_cmp++;
    if (misalign !== 1'b0 || ID_pc !== 32'h40 || ID_inst !== rom[16]) begin
      n_bad++;
      $display("FAIL misalign_pulse: got mis=%b pc=%h inst=%h want 0/40/%h", misalign, ID_pc, ID_inst, rom[16]);
    end
  endtask

  task automatic test_random();
    logic s, w, r;
    logic [31:0] rpc;
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      s   = ($urandom_range(0, 3) == 0);
      w   = s ? 1'b0 : ($urandom_range(0, 4) != 0);
      r   = ($urandom_range(0, 9) == 0);
      rpc = ($urandom_range(0, 9) == 0) ? $urandom : 32'(($urandom_range(0, 255) << 2) | $urandom_range(0, 3));
      cycle(0, w, s, r, rpc);
      n_cmp++;
      if ({IF_pc, ID_pc, ID_pc_plus4, ID_inst, ID_valid, misalign, seq_err, fetch_cnt, stall_cnt}
          !== {m_pc, m_id_pc, m_id_pc4, m_id_inst, m_id_valid, m_mis, m_seq, m_fetch, m_stall}) begin
        n_bad++;
        $display("FAIL random_%0d: got pc=%h idpc=%h pc4=%h inst=%h v=%b mis=%b seq=%b fc=%h sc=%h want pc=%h idpc=%h pc4=%h inst=%h v=%b mis=%b seq=%b fc=%h sc=%h",
                 i, IF_pc, ID_pc, ID_pc_plus4, ID_inst, ID_valid, misalign, seq_err, fetch_cnt, stall_cnt,
                 m_pc, m_id_pc, m_id_pc4, m_id_inst, m_id_valid, m_mis, m_seq, m_fetch, m_stall);
      end
    end
  endtask

  task automatic test_fetch_wrap();
    logic [31:0] sc_before;
    cycle(0, 1, 0, 0, 0);
    sc_before = m_stall;
    drive(0, 1, 0, 0, 0);
    force dut.fetch_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.fetch_cnt;
    m_fetch = 32'hFFFF_FFFF;
    edge_update();
    n_cmp++;
    if (fetch_cnt !== 32'h0 || stall_cnt !== sc_before) begin
      n_bad++;
      $display("FAIL fetch_wrap: got fc=%h sc=%h want 0/%h", fetch_cnt, stall_cnt, sc_before);
    end
  endtask

  task automatic test_seq_err();
    logic [31:0] pc_before, id_before;
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    pc_before = IF_pc;
    id_before = ID_inst;
    cycle(0, 1, 1, 0, 0);
    n_cmp++;
    if (seq_err !== 1'b1 || IF_pc !== pc_before + 32'd4 || ID_inst !== id_before) begin
      n_bad++;
      $display("FAIL seq_err_set: got seq=%b ifpc=%h inst=%h want 1/%h/%h",
               seq_err, IF_pc, ID_inst, pc_before + 32'd4, id_before);
    end
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, i == 1, 32'h80);
    n_cmp++;
    if (seq_err !== 1'b1) begin
      n_bad++; $display("FAIL seq_err_sticky: got %b want 1", seq_err);
    end
  endtask

  task automatic test_reset_mid_stall();
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 1, 0, 0);
    cycle(1, 1, 1, 1, 32'h42);
    n_cmp++;
    if ({IF_pc, ID_pc, ID_pc_plus4, ID_inst, ID_valid, misalign, seq_err, fetch_cnt, stall_cnt}
        !== {RESET_PC, 32'h0, 32'h0, NOP_INST, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0}) begin
      n_bad++;
      $display("FAIL reset_mid_stall: got pc=%h idpc=%h idpc4=%h inst=%h v=%b mis=%b seq=%b fc=%h sc=%h",
               IF_pc, ID_pc, ID_pc_plus4, ID_inst, ID_valid, misalign, seq_err, fetch_cnt, stall_cnt);
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) rom[i] = (i < 64) ? 32'(i + 1) : $urandom;
    reset = 1'b1; WPC = 1'b0; ID_stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    test_reset();
    test_free_run();
    test_stall();
    test_redirect_during_stall();
    test_misalign();
    test_random();
    test_fetch_wrap();
    test_seq_err();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
